// File: rtl/fifo_param_if.sv
// ============================================================================
// Module   : fifo_param_if
// Brief    : Handshake/data bundle between a FIFO producer/consumer and fifo_param.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_param_if #(
    parameter int DATA_WIDTH = 6,
    parameter int PTR_WIDTH  = 3
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [PTR_WIDTH:0]    fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  al_empty;
    logic                  al_full;
    logic                  err_fifo;

    modport master (
        output data_in, fifo_wr, fifo_rd,
        input  data_out, valid_out, fifo_count, fifo_empty, fifo_full,
               al_empty, al_full, err_fifo
    );

    modport slave (
        input  data_in, fifo_wr, fifo_rd,
        output data_out, valid_out, fifo_count, fifo_empty, fifo_full,
               al_empty, al_full, err_fifo
    );
endinterface

`default_nettype wire

// File: rtl/fifo_param.sv
// ============================================================================
// Module   : fifo_param
// Brief    : Parametrised synchronous FIFO with registered read port, occupancy
//            count and watermark flags. Define FIFO_STICKY_ERR_EN to make
//            err_fifo latch until RESET instead of pulsing per bad request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_param #(
    parameter int DATA_WIDTH   = 6,
    parameter int FIFO_DEPTH   = 8,
    parameter int PTR_WIDTH    = 3,
    parameter int AL_FULL_THR  = 6,
    parameter int AL_EMPTY_THR = 2
) (
    input  wire logic   clk,
    input  wire logic   RESET,
    fifo_param_if.slave bus
);

    localparam logic [PTR_WIDTH:0]   c_depth     = (PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0]   c_al_full   = (PTR_WIDTH+1)'(AL_FULL_THR);
    localparam logic [PTR_WIDTH:0]   c_al_empty  = (PTR_WIDTH+1)'(AL_EMPTY_THR);
    localparam logic [PTR_WIDTH-1:0] c_ptr_one   = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   c_count_one = (PTR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_err;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_err;

    // Flags decode only the registered count, so they never depend on rd/wr.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // A read frees a slot in the same edge, so a full FIFO still accepts rd+wr.
    assign w_rd_ok = bus.fifo_rd && !w_empty;
    assign w_wr_ok = bus.fifo_wr && (!w_full || w_rd_ok);
    assign w_err   = (bus.fifo_wr && !w_wr_ok) || (bus.fifo_rd && w_empty);

    always_ff @(posedge clk) begin
        if (!RESET && w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_ok;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            r_err <= r_err | w_err;
`else
            r_err <= w_err;
`endif
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.fifo_count = r_count;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.al_empty   = (r_count <= c_al_empty);
    assign bus.al_full    = (r_count >= c_al_full);
    assign bus.err_fifo   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// ============================================================================
// Module   : tb_fifo_param
// Brief    : Self-checking bench for fifo_param (directed table + random vs queue model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_param;

    localparam int DW    = 6;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int AFT   = 6;
    localparam int AET   = 2;
`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;

    fifo_param_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    fifo_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW),
        .AL_FULL_THR(AFT), .AL_EMPTY_THR(AET)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       wr;
        bit       rd;
        bit [5:0] din;
        int       count;
        bit       valid;
        bit [5:0] dout;
        bit       err;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a plain queue of stored words plus the output registers.
    bit [5:0] mq[$];
    bit [5:0] m_dout;
    bit       m_valid;
    bit       m_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt, input bit v,
                                 input bit [5:0] d, input bit e);
        check({tag, " count"},    int'(bus.fifo_count), cnt);
        check({tag, " valid"},    int'(bus.valid_out), int'(v));
        check({tag, " dout"},     int'(bus.data_out), int'(d));
        check({tag, " err"},      int'(bus.err_fifo), int'(e));
        check({tag, " empty"},    int'(bus.fifo_empty), int'(cnt == 0));
        check({tag, " full"},     int'(bus.fifo_full), int'(cnt == DEPTH));
        check({tag, " al_empty"}, int'(bus.al_empty), int'(cnt <= AET));
        check({tag, " al_full"},  int'(bus.al_full), int'(cnt >= AFT));
    endtask

    task automatic model_step(input bit rst, input bit wr, input bit rd, input bit [5:0] din);
        bit rd_ok, wr_ok, bad;
        if (rst) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            rd_ok = rd && (mq.size() != 0);
            wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
            bad   = (wr && !wr_ok) || (rd && mq.size() == 0);
            if (rd_ok) m_dout = mq.pop_front();
            m_valid = rd_ok;
            if (wr_ok) mq.push_back(din);
            m_err = STICKY ? (m_err | bad) : bad;
        end
    endtask

    task automatic drive(input bit rst, input bit wr, input bit rd, input bit [5:0] din);
        RESET       = rst;
        bus.fifo_wr = wr;
        bus.fifo_rd = rd;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle(input string tag, input bit rst, input bit wr,
                               input bit rd, input bit [5:0] din);
        model_step(rst, wr, rd, din);
        drive(rst, wr, rd, din);
        check_outputs(tag, mq.size(), m_valid, m_dout, m_err);
    endtask

    function automatic vec_t mk(input bit rst, input bit wr, input bit rd, input bit [5:0] din,
                                input int cnt, input bit v, input bit [5:0] d, input bit e);
        vec_t t;
        t.rst = rst; t.wr = wr; t.rd = rd; t.din = din;
        t.count = cnt; t.valid = v; t.dout = d; t.err = e;
        return t;
    endfunction

    initial begin
        RESET = 1'b1;
        bus.fifo_wr = 1'b0;
        bus.fifo_rd = 1'b0;
        bus.data_in = '0;

        // Directed table: fill/drain, overflow, rd+wr when full/empty, mid-stream reset.
        vecs.push_back(mk(1, 0, 0, 6'h00, 0, 0, 6'h00, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 6'(i), i, 0, 6'h00, 0));
        vecs.push_back(mk(0, 1, 0, 6'h3F, 8, 0, 6'h00, 1));
        vecs.push_back(mk(0, 1, 1, 6'h2A, 8, 1, 6'h01, STICKY));
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(0, 0, 1, 6'h00, 8 - k, 1, 6'(k + 1), STICKY));
        vecs.push_back(mk(0, 0, 1, 6'h00, 0, 1, 6'h2A, STICKY));
        vecs.push_back(mk(0, 0, 1, 6'h00, 0, 0, 6'h2A, 1));
        vecs.push_back(mk(0, 1, 1, 6'h15, 1, 0, 6'h2A, 1));
        vecs.push_back(mk(0, 0, 1, 6'h00, 0, 1, 6'h15, STICKY));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 6'(6'h10 + i), i + 1, 0, 6'h15, STICKY));
        vecs.push_back(mk(1, 0, 0, 6'h00, 0, 0, 6'h00, 0));
        vecs.push_back(mk(0, 0, 1, 6'h00, 0, 0, 6'h00, 1));
        vecs.push_back(mk(0, 0, 0, 6'h00, 0, 0, 6'h00, STICKY));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_outputs($sformatf("vec%0d", i), vecs[i].count, vecs[i].valid,
                          vecs[i].dout, vecs[i].err);
        end

        // Pointer wrap: 5 in, 5 out, then 10 write requests (last two overflow).
        model_cycle("wrap rst", 1, 0, 0, 6'h00);
        for (int i = 0; i < 5; i++) model_cycle("wrap w5", 0, 1, 0, 6'(i + 1));
        for (int i = 0; i < 5; i++) model_cycle("wrap r5", 0, 0, 1, 6'h00);
        for (int i = 0; i < 10; i++) begin
            model_cycle("wrap w10", 0, 1, 0, 6'(6'h20 + i));
            if (i == 1) check("al_empty at 2", int'(bus.al_empty), 1);
            if (i == 2) check("al_empty at 3", int'(bus.al_empty), 0);
            if (i == 5) check("al_full at 6", int'(bus.al_full), 1);
            if (i == 9) check("count after 10 wr", int'(bus.fifo_count), 8);
        end
        for (int i = 0; i < 8; i++) model_cycle("wrap drain", 0, 0, 1, 6'h00);
        check("wrap last data", int'(bus.data_out), 6'h27);

        // Randomised traffic against the queue model.
        model_cycle("rnd rst", 1, 0, 0, 6'h00);
        for (int n = 0; n < 600; n++) begin
            bit r_rst, r_wr, r_rd;
            int phase;
            phase = (n / 100) % 3;
            r_rst = ($urandom_range(0, 79) == 0);
            r_wr  = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            r_rd  = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            model_cycle("rnd", r_rst, r_wr, r_rd, 6'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
